// File: rtl/tdm_demux.sv
// Bit-serial TDM receiver: frame-sync tracking, slot/bit counting and per-channel word delivery.
// Core state runs one stage ahead of the registered output bank, so every output lags its causing bit by one edge.
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         sync,
    output logic [CHANNELS*WIDTH-1:0]    ch_data,
    output logic [CHANNELS-1:0]          ch_valid,
    output logic                         frame_done,
    output logic                         frame_error,
    output logic                         locked
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [BW-1:0]    BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0]    BIT_ONE   = BW'(1);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [SW-1:0]    SLOT_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0]    SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0]    SLOT_LAST = SW'(CHANNELS - 1);
    localparam logic [WIDTH-2:0] SH_ZERO   = {(WIDTH-1){1'b0}};

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e                      state_q,     state_d;
    logic [BW-1:0]               bit_cnt_q,   bit_cnt_d;
    logic [SW-1:0]               slot_cnt_q,  slot_cnt_d;
    logic [WIDTH-1:0]            shreg_q,     shreg_d;
    logic                        wr_stb_q,    wr_stb_d;
    logic [SW-1:0]               wr_slot_q,   wr_slot_d;
    logic                        last_stb_q,  last_stb_d;
    logic                        err_stb_q,   err_stb_d;
    logic [CHANNELS*WIDTH-1:0]   ch_data_q,   ch_data_d;
    logic [CHANNELS-1:0]         ch_valid_q,  ch_valid_d;
    logic                        frame_done_q,  frame_done_d;
    logic                        frame_error_q, frame_error_d;
    logic                        locked_q,    locked_d;
    logic                        at_start_s;

    assign at_start_s = (bit_cnt_q == BIT_ZERO) && (slot_cnt_q == SLOT_ZERO);

    // Framing core: position tracking, sync checking and word completion.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;
        shreg_d    = shreg_q;
        wr_stb_d   = 1'b0;
        wr_slot_d  = wr_slot_q;
        last_stb_d = 1'b0;
        err_stb_d  = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        state_d    = RECV;
                        shreg_d    = {SH_ZERO, din};
                        bit_cnt_d  = BIT_ONE;
                        slot_cnt_d = SLOT_ZERO;
                    end else begin
                        state_d    = HUNT;
                    end
                end
                RECV: begin
                    if (sync && !at_start_s) begin
                        // Early sync restarts the frame on this bit; the partial slot is dropped.
                        err_stb_d  = 1'b1;
                        shreg_d    = {SH_ZERO, din};
                        bit_cnt_d  = BIT_ONE;
                        slot_cnt_d = SLOT_ZERO;
                    end else if (!sync && at_start_s) begin
                        err_stb_d  = 1'b1;
                        state_d    = HUNT;
                        shreg_d    = {WIDTH{1'b0}};
                        bit_cnt_d  = BIT_ZERO;
                        slot_cnt_d = SLOT_ZERO;
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], din};
                        if (bit_cnt_q == BIT_LAST) begin
                            wr_stb_d  = 1'b1;
                            wr_slot_d = slot_cnt_q;
                            bit_cnt_d = BIT_ZERO;
                            if (slot_cnt_q == SLOT_LAST) begin
                                slot_cnt_d = SLOT_ZERO;
                                last_stb_d = 1'b1;
                            end else begin
                                slot_cnt_d = slot_cnt_q + SLOT_ONE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end
                end
                default: begin
                    state_d    = HUNT;
                    bit_cnt_d  = BIT_ZERO;
                    slot_cnt_d = SLOT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output bank: completed word sits in shreg_q for one cycle and is copied to its channel here.
    always_comb begin
        ch_data_d     = ch_data_q;
        ch_valid_d    = {CHANNELS{1'b0}};
        frame_done_d  = last_stb_q;
        frame_error_d = err_stb_q;
        locked_d      = (state_q == RECV);
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_stb_q && (wr_slot_q == SW'(c))) begin
                ch_data_d[c*WIDTH +: WIDTH] = shreg_q;
                ch_valid_d[c]               = 1'b1;
            end else begin
                ch_valid_d[c]               = 1'b0;
            end
        end
    end

    // All state and output registers with synchronous reset priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= HUNT;
            bit_cnt_q     <= BIT_ZERO;
            slot_cnt_q    <= SLOT_ZERO;
            shreg_q       <= {WIDTH{1'b0}};
            wr_stb_q      <= 1'b0;
            wr_slot_q     <= SLOT_ZERO;
            last_stb_q    <= 1'b0;
            err_stb_q     <= 1'b0;
            ch_data_q     <= {(CHANNELS*WIDTH){1'b0}};
            ch_valid_q    <= {CHANNELS{1'b0}};
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            shreg_q       <= shreg_d;
            wr_stb_q      <= wr_stb_d;
            wr_slot_q     <= wr_slot_d;
            last_stb_q    <= last_stb_d;
            err_stb_q     <= err_stb_d;
            ch_data_q     <= ch_data_d;
            ch_valid_q    <= ch_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            locked_q      <= locked_d;
        end
    end

    assign ch_data     = ch_data_q;
    assign ch_valid    = ch_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign locked      = locked_q;

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side time-division demultiplexer: the counterpart of the 2:1 select multiplexer the team already uses to merge channels. It takes a bit-serial TDM stream with frame sync, tracks slot and bit position, and distributes each slot's bits into per-channel parallel output registers. Each channel raises a one-cycle valid strobe when its word lands. It sits between a serial link or line decoder and the per-channel consumers.

## Interface
- CHANNELS, 4: channels (slots) per frame; ≥2.
- WIDTH, 8: bits per slot; ≥2.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- din  in  1  serial data bit, MSB of each slot first.
- din_valid  in  1  din carries a bit this cycle; when low, all position state holds.
- sync  in  1  marks bit 0 of slot 0 (frame start); meaningful only when din_valid=1.
- ch_data  out  CHANNELS*WIDTH  channel c word at bits [c*WIDTH +: WIDTH]; registered.
- ch_valid  out  CHANNELS  one-cycle strobe, bit c when channel c word updated.
- frame_done  out  1  one-cycle strobe, last slot of a frame delivered.
- frame_error  out  1  one-cycle strobe, sync protocol violation.
- locked  out  1  high while in RECV state.

## Operation
- States: HUNT, RECV. Counters: bit_cnt (0..WIDTH-1) and slot_cnt (0..CHANNELS-1). WIDTH-bit shift register shreg shifts left, din into LSB.
- Reset: state=HUNT, bit_cnt=0, slot_cnt=0, shreg=0, ch_data=0, ch_valid=0, frame_done=0, frame_error=0, locked=0.
- HUNT: ignore bits until din_valid&sync. That bit is frame bit 0. Go to RECV. Load shreg with din. Set bit_cnt=1, slot_cnt=0.
- RECV, din_valid=1, no sync violation: shift din in and increment bit_cnt.
- Slot end: when bit_cnt=WIDTH-1, the completed word {shreg[WIDTH-2:0],din} is written to ch_data slot slot_cnt and ch_valid[slot_cnt] pulses. bit_cnt wraps to 0 and slot_cnt increments.
- Frame end: when slot_cnt=CHANNELS-1 completes, frame_done pulses with ch_valid[CHANNELS-1], and slot_cnt wraps to 0. State stays RECV.
- Next frame start (bit_cnt=0, slot_cnt=0 in RECV) requires sync=1 with din_valid.
  - If sync=0: pulse frame_error, go to HUNT, discard the bit.
- Sync at any other position in RECV: pulse frame_error and resync immediately. That bit becomes the new frame bit 0 (state RECV, bit_cnt=1, slot_cnt=0). The partial slot is discarded and no ch_valid pulses for it.
- din_valid=0: nothing changes. Strobes are low and sync is ignored.
- ch_data words retain their values until overwritten. They are not cleared on error or on HUNT; only reset clears them.
- Only one ch_valid bit is ever high in a cycle.

## Timing
- Latency: a word's last bit is accepted at edge t. ch_data and ch_valid are visible after edge t+1, i.e. registered 1 cycle.
- The minimum frame is CHANNELS*WIDTH accepted bits. Gaps (din_valid=0) extend it arbitrarily without error.
- The frame_error strobe appears one cycle after the offending bit is sampled. locked falls in that same cycle when the transition is to HUNT.
- reset mid-frame: the next edge forces the reset values regardless of din/sync. Partial data is lost.
- reset has priority over all inputs.

## Test plan
- Reset: hold reset 2 cycles with din=1, sync=1, din_valid=1. Required: all outputs 0 and locked=0 after each edge.
- Clean frame (CHANNELS=4, WIDTH=8): send 0xA5,0x3C,0xFF,0x01 MSB-first, sync with the first bit, din_valid always 1. Required:
  - ch_valid pulses 0001, 0010, 0100, 1000 at cycles 9, 17, 25, 33 after the sync bit.
  - ch_data = 0x01FF3CA5.
  - frame_done coincides with ch_valid=1000.
- Gapped input: same frame with din_valid=0 on every third cycle. Required: identical ch_data and no frame_error; strobes are delayed by the gap count.
- Missing sync: two frames, with sync omitted on the second frame's first bit. Required:
  - frame_error pulses once.
  - locked falls.
  - ch_data keeps the first frame's values.
  - Relock on the next sync.
- Early sync: sync asserted on bit 13 of a frame. Required:
  - frame_error pulses.
  - Only ch_valid[0] fires for that frame.
  - The new frame decodes correctly from bit 13.
- Reset mid-operation: assert reset during slot 2. Required: all outputs 0 next cycle and HUNT state; a subsequent clean frame decodes correctly.
